line_cache: RTL
===============

LINE_CACHE -- requirements
Module: line_cache

Interface
REQ-001 The parameter list SHALL be: INDEX_W, 8, log2 of line count (256 lines of 128 bits, direct-mapped, write-back).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-003 Ports SHALL be, with clock and reset first:
- clk  in  1  clock
- rst  in  1  sync reset, active high
- req_valid  in  1  CPU request valid
- req_ready  out  1  CPU request accepted when both high
- req_we  in  1  1 = write, 0 = read
- req_addr  in  27  byte address; bits [1:0] ignored
- req_wdata  in  32  write word
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  read word (write: echoes req_wdata)
- wr_data  out  128  writeback line
- wr_addr  out  27  writeback line address, bits [3:0] = 0
- wr_valid  out  1  writeback request
- wr_ready  in  1  writeback channel idle
- rd_addr  out  27  fill line address, bits [3:0] = 0
- rd_avalid  out  1  fill request
- rd_aready  in  1  fill request accepted
- rd_data  in  128  fill line data
- rd_valid  in  1  fill data valid
- rd_dready  out  1  fill data accepted

Function
REQ-004 Address split SHALL be: word offset [3:2]; index [INDEX_W+3:4]; tag [26:INDEX_W+4].
REQ-005 FSM states SHALL be IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 IDLE: on req_valid & req_ready, the block SHALL latch the request, start the synchronous tag/data read, and go to LOOKUP.
REQ-007 LOOKUP: on a hit (valid & tag match), the block SHALL go to RESP.
- Read hit: resp_rdata = selected word.
- Write hit: merge the word into the line and set dirty.
REQ-008 Hit latency: resp_valid SHALL be high exactly 2 cycles after request acceptance, for 1 cycle; the block SHALL return to IDLE in the same cycle.
REQ-009 LOOKUP on a miss: if the victim is valid & dirty, the block SHALL copy the victim into the writeback buffer and go to WB; otherwise it SHALL go to FILL_REQ.
REQ-010 WB: wr_valid = 1 and wr_addr = {victim tag, index, 4'b0}.
- On wr_valid & wr_ready: drop wr_valid and go to FILL_REQ.
- wr_data and wr_addr SHALL stay stable until the next writeback starts.
REQ-011 FILL_REQ: rd_avalid SHALL be asserted only while wr_ready = 1, so no fill overtakes an in-flight writeback; rd_addr = {req tag, index, 4'b0}.
- On rd_avalid & rd_aready: go to FILL_WAIT.
- rd_addr SHALL stay stable while rd_avalid is high.
REQ-012 FILL_WAIT: rd_dready = 1. On rd_valid, the block SHALL install the line (valid = 1, dirty = 0), apply the write merge (dirty = 1) or select the read word, and go to RESP.
REQ-013 rd_dready SHALL be 0 in every state except FILL_WAIT; wr_valid and rd_avalid SHALL never be high together.
REQ-014 Valid and dirty bits SHALL be held in flops; tag and data SHALL be held in synchronous-read arrays.

Reset
REQ-015 While rst = 1, the outputs SHALL be: req_ready = 0, resp_valid = 0, resp_rdata = 0, wr_valid = 0, rd_avalid = 0, rd_dready = 0, wr_data = 0, wr_addr = 0, rd_addr = 0.
REQ-016 Reset SHALL clear all valid and dirty bits and force the FSM to IDLE; req_ready = 1 from the first cycle after rst falls.
REQ-017 Reset mid-transaction SHALL abandon the transaction without a response; the downstream master shares rst and also resets.

Configuration
REQ-018 With LINE_CACHE_STATS_EN defined, the block SHALL add outputs hit_cnt [31:0] and miss_cnt [31:0].
- Each counter increments once per LOOKUP outcome, wraps at 2^32 and resets to 0.
- Without the macro, these ports and their logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-019 Read 0x0000104 after reset -> rd_addr = 0x0000100; return rd_data word1 = 0x11111111 -> resp_rdata = 0x11111111; repeating the read -> resp_valid 2 cycles after acceptance, rd_avalid never asserted.
REQ-020 Write 0x0000108 with 0xDEADBEEF (line resident) -> hit, no memory traffic; read 0x0000108 -> resp_rdata = 0xDEADBEEF.
REQ-021 Then read 0x0001108 (same index) -> wr_valid with wr_addr = 0x0000100 and wr_data[95:64] = 0xDEADBEEF, then rd_addr = 0x0001100.
REQ-022 Hold rd_aready = 0 for 10 cycles -> rd_avalid and rd_addr stay stable; hold wr_ready = 0 after the WB handshake -> rd_avalid stays 0 until wr_ready = 1.
REQ-023 Assert rst for 1 cycle during FILL_WAIT -> all outputs at reset values, no resp_valid; re-reading the same address misses.
REQ-024 With LINE_CACHE_STATS_EN, the sequence in REQ-019 -> miss_cnt = 1, hit_cnt = 1.

Source files
------------

// File: rtl/line_cache.sv
// line_cache: direct-mapped, write-back line cache with 2**INDEX_W lines of
// 128 bits, placed between a 32-bit CPU request port and a 128-bit line port.
//
// Optional feature: define LINE_CACHE_STATS_EN to add the hit_cnt/miss_cnt
// outputs. Without it those ports and their counters do not exist.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_*           CPU request (valid/ready), we, byte address, write word
//   resp_valid      one-cycle completion pulse, resp_rdata = read word
//                   (a write echoes its write word)
//   wr_*            writeback of a dirty victim line (valid/ready)
//   rd_a*           fill address request (valid/ready)
//   rd_data/valid   fill data return, accepted with rd_dready
//   hit_cnt/miss_cnt  LOOKUP outcome counters (LINE_CACHE_STATS_EN only)
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high; a valid, once raised, holds its payload until that edge.
// Address split: word [3:2], index [INDEX_W+3:4], tag [26:INDEX_W+4].
module line_cache #(
  parameter int INDEX_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [26:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic [127:0] wr_data,
  output logic [26:0]  wr_addr,
  output logic         wr_valid,
  input  logic         wr_ready,
  output logic [26:0]  rd_addr,
  output logic         rd_avalid,
  input  logic         rd_aready,
  input  logic [127:0] rd_data,
  input  logic         rd_valid,
  output logic         rd_dready
`ifdef LINE_CACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 27 - INDEX_W - 4;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESP
  } state_t;

  state_t r_state, w_next;

  // Latched request
  logic               r_we;
  logic [TAG_W-1:0]   r_tag;
  logic [INDEX_W-1:0] r_idx;
  logic [1:0]         r_off;
  logic [31:0]        r_wdata;

  // Tag/data arrays (synchronous read) and their read registers
  logic [TAG_W-1:0]   r_tag_mem  [LINES];
  logic [127:0]       r_data_mem [LINES];
  logic [TAG_W-1:0]   r_tag_q;
  logic [127:0]       r_data_q;

  // Per-line state in flops so reset can clear it in one cycle
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;

  logic [31:0]        r_rdata;
  logic [127:0]       r_wb_data;
  logic [26:0]        r_wb_addr;
  logic [26:0]        r_fill_addr;

  logic               w_accept;
  logic               w_hit;
  logic               w_victim_dirty;
  logic               w_fill_done;
  logic               w_arr_we;
  logic [INDEX_W-1:0] w_req_idx;
  logic [127:0]       w_line_base;
  logic [127:0]       w_line_merged;
  logic [127:0]       w_line_wr;
  logic [31:0]        w_word;
  logic               w_unused_ok;

  assign w_req_idx   = req_addr[INDEX_W+3:4];
  assign w_unused_ok = ^req_addr[1:0];

  assign w_hit          = r_valid[r_idx] && (r_tag_q == r_tag);
  assign w_victim_dirty = r_valid[r_idx] && r_dirty[r_idx];
  assign w_accept       = req_valid && req_ready;
  assign w_fill_done    = rd_valid && rd_dready;

  // The line being updated comes from the array on a hit and from the
  // fill bus when a miss completes; a write merges its word into it.
  always_comb begin
    w_line_base   = (r_state == FILL_WAIT) ? rd_data : r_data_q;
    w_word        = w_line_base[{r_off, 5'b0} +: 32];
    w_line_merged = w_line_base;
    w_line_merged[{r_off, 5'b0} +: 32] = r_wdata;
    w_line_wr     = r_we ? w_line_merged : w_line_base;
  end

  assign w_arr_we = !rst && (((r_state == LOOKUP) && w_hit && r_we) || w_fill_done);

  // Next state and handshake outputs. Reset masks every output in the same
  // cycle it is seen, so an abandoned transaction shows nothing downstream.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    wr_valid   = 1'b0;
    rd_avalid  = 1'b0;
    rd_dready  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit)               w_next = RESP;
        else if (w_victim_dirty) w_next = WB;
        else                     w_next = FILL_REQ;
      end
      WB: begin
        wr_valid = 1'b1;
        if (wr_ready) w_next = FILL_REQ;
      end
      FILL_REQ: begin
        // Hold the fill back while a writeback is still draining.
        rd_avalid = wr_ready;
        if (wr_ready && rd_aready) w_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        rd_dready = 1'b1;
        if (rd_valid) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      wr_valid   = 1'b0;
      rd_avalid  = 1'b0;
      rd_dready  = 1'b0;
      w_next     = IDLE;
    end
  end

  assign resp_rdata = rst ? '0 : r_rdata;
  assign wr_data    = rst ? '0 : r_wb_data;
  assign wr_addr    = rst ? '0 : r_wb_addr;
  assign rd_addr    = rst ? '0 : r_fill_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_we        <= 1'b0;
      r_tag       <= '0;
      r_idx       <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_wb_data   <= '0;
      r_wb_addr   <= '0;
      r_fill_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_tag   <= req_addr[26:INDEX_W+4];
        r_idx   <= w_req_idx;
        r_off   <= req_addr[3:2];
        r_wdata <= req_wdata;
      end
      if (r_state == LOOKUP) begin
        if (w_hit) begin
          r_rdata <= r_we ? r_wdata : w_word;
          if (r_we) r_dirty[r_idx] <= 1'b1;
        end else begin
          r_fill_addr <= {r_tag, r_idx, 4'b0};
          // The writeback buffer keeps its contents until the next dirty miss.
          if (w_victim_dirty) begin
            r_wb_data <= r_data_q;
            r_wb_addr <= {r_tag_q, r_idx, 4'b0};
          end
        end
      end
      if (w_fill_done) begin
        r_valid[r_idx] <= 1'b1;
        r_dirty[r_idx] <= r_we;
        r_rdata        <= r_we ? r_wdata : w_word;
      end
    end
  end

  // Arrays: read on acceptance, written on a write hit or a completed fill.
  // Reads and writes never coincide because acceptance only happens in IDLE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_q  <= r_tag_mem[w_req_idx];
      r_data_q <= r_data_mem[w_req_idx];
    end
    if (w_arr_we) begin
      r_tag_mem[r_idx]  <= r_tag;
      r_data_mem[r_idx] <= w_line_wr;
    end
  end

`ifdef LINE_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (r_state == LOOKUP) begin
      if (w_hit) hit_cnt  <= hit_cnt + 32'd1;
      else       miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
